// File: rtl/mem_wr_pairer.sv
// rtl/mem_wr_pairer.sv - pairs independently buffered write requests and write-data beats
// Optional `MEM_WR_PAIRER_LAST_CHECK_EN: accepted beats without last_i set a sticky err_o.
`timescale 1ns/1ps

module mem_wr_pairer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  // Full-check uses the registered count only, so a pop never frees room for a same-cycle push.
  assign do_push = push_i && (count_o != FULL_CNT);
  assign do_pop  = pop_i && (count_o != '0);
  assign rdata_o = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr    <= '0;
      rptr    <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + (AW+1)'(1);
        2'b01:   count_o <= count_o - (AW+1)'(1);
        default: count_o <= count_o;
      endcase
    end
  end
endmodule

module mem_wr_pairer #(
  parameter int ADDR_SIZE  = 32,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 8,
  parameter int SIZE_WIDTH = 4,
  parameter int REQ_DEPTH  = 4,
  parameter int DATA_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [ADDR_SIZE-1:0]          req_addr_i,
  input  logic [SIZE_WIDTH-1:0]         req_size_i,
  input  logic [ID_WIDTH-1:0]           req_id_i,
  input  logic [1:0]                    req_cmd_i,
  input  logic [3:0]                    req_atomic_i,
  input  logic                          data_valid_i,
  output logic                          data_ready_o,
  input  logic [DATA_WIDTH-1:0]         data_i,
  input  logic [DATA_WIDTH/8-1:0]       be_i,
  input  logic                          last_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [ADDR_SIZE-1:0]          out_addr_o,
  output logic [SIZE_WIDTH-1:0]         out_size_o,
  output logic [ID_WIDTH-1:0]           out_id_o,
  output logic [1:0]                    out_cmd_o,
  output logic [3:0]                    out_atomic_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [DATA_WIDTH/8-1:0]       out_be_o,
  output logic [$clog2(REQ_DEPTH):0]    req_count_o,
  output logic [$clog2(DATA_DEPTH):0]   data_count_o,
  output logic                          err_o
);
  localparam int RW = ADDR_SIZE + SIZE_WIDTH + ID_WIDTH + 2 + 4;
  localparam int DW = DATA_WIDTH + DATA_WIDTH/8;
  localparam logic [$clog2(REQ_DEPTH):0]  REQ_FULL  = REQ_DEPTH[$clog2(REQ_DEPTH):0];
  localparam logic [$clog2(DATA_DEPTH):0] DATA_FULL = DATA_DEPTH[$clog2(DATA_DEPTH):0];

  logic [RW-1:0]           req_head;
  logic [DW-1:0]           data_head;
  logic [ADDR_SIZE-1:0]    head_addr;
  logic [SIZE_WIDTH-1:0]   head_size;
  logic [ID_WIDTH-1:0]     head_id;
  logic [1:0]              head_cmd;
  logic [3:0]              head_atomic;
  logic [DATA_WIDTH-1:0]   head_data;
  logic [DATA_WIDTH/8-1:0] head_be;
  logic                    req_acc;
  logic                    data_acc;
  logic                    pop;

  assign req_ready_o  = (req_count_o != REQ_FULL);
  assign data_ready_o = (data_count_o != DATA_FULL);
  assign req_acc      = req_valid_i && req_ready_o;
  assign data_acc     = data_valid_i && data_ready_o;
  assign out_valid_o  = (req_count_o != '0) && (data_count_o != '0);
  assign pop          = out_valid_o && out_ready_i;

  mem_wr_pairer_fifo #(.WIDTH(RW), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (req_acc),
    .wdata_i ({req_addr_i, req_size_i, req_id_i, req_cmd_i, req_atomic_i}),
    .pop_i   (pop),
    .rdata_o (req_head),
    .count_o (req_count_o)
  );

  mem_wr_pairer_fifo #(.WIDTH(DW), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (data_acc),
    .wdata_i ({data_i, be_i}),
    .pop_i   (pop),
    .rdata_o (data_head),
    .count_o (data_count_o)
  );

  assign {head_addr, head_size, head_id, head_cmd, head_atomic} = req_head;
  assign {head_data, head_be} = data_head;

  // Fields are masked to zero whenever no pair is presented.
  assign out_addr_o   = out_valid_o ? head_addr   : '0;
  assign out_size_o   = out_valid_o ? head_size   : '0;
  assign out_id_o     = out_valid_o ? head_id     : '0;
  assign out_cmd_o    = out_valid_o ? head_cmd    : '0;
  assign out_atomic_o = out_valid_o ? head_atomic : '0;
  assign out_data_o   = out_valid_o ? head_data   : '0;
  assign out_be_o     = out_valid_o ? head_be     : '0;

`ifdef MEM_WR_PAIRER_LAST_CHECK_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) err_o <= 1'b0;
    else if (data_acc && !last_i) err_o <= 1'b1;
  end
`else
  logic unused_last;
  assign unused_last = last_i;
  assign err_o       = 1'b0;
`endif
endmodule

// File: tb/tb_mem_wr_pairer.sv
// tb/tb_mem_wr_pairer.sv - directed vector table and corner sequences for mem_wr_pairer
`timescale 1ns/1ps

module tb_mem_wr_pairer;
  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic         req_valid_i, req_ready_o;
  logic [31:0]  req_addr_i;
  logic [3:0]   req_size_i;
  logic [7:0]   req_id_i;
  logic [1:0]   req_cmd_i;
  logic [3:0]   req_atomic_i;
  logic         data_valid_i, data_ready_o;
  logic [511:0] data_i;
  logic [63:0]  be_i;
  logic         last_i;
  logic         out_valid_o, out_ready_i;
  logic [31:0]  out_addr_o;
  logic [3:0]   out_size_o;
  logic [7:0]   out_id_o;
  logic [1:0]   out_cmd_o;
  logic [3:0]   out_atomic_o;
  logic [511:0] out_data_o;
  logic [63:0]  out_be_o;
  logic [2:0]   req_count_o, data_count_o;
  logic         err_o;

  int checks = 0;
  int errors = 0;

  mem_wr_pairer dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_id_i(req_id_i),
    .req_cmd_i(req_cmd_i), .req_atomic_i(req_atomic_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .data_i(data_i), .be_i(be_i), .last_i(last_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_addr_o(out_addr_o), .out_size_o(out_size_o), .out_id_o(out_id_o),
    .out_cmd_o(out_cmd_o), .out_atomic_o(out_atomic_o),
    .out_data_o(out_data_o), .out_be_o(out_be_o),
    .req_count_o(req_count_o), .data_count_o(data_count_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic [7:0]  id;
    logic [1:0]  cmd;
    logic        dv;
    logic [7:0]  dtag;
    logic        ordy;
    logic        rr;
    logic        dr;
    logic        ov;
    logic [31:0] eaddr;
    logic [7:0]  eid;
    logic [1:0]  ecmd;
    logic [2:0]  rc;
    logic [2:0]  dc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int rv, input logic [31:0] addr, input int id, input int cmd,
                              input int dv, input int dtag, input int ordy,
                              input int rr, input int dr, input int ov, input logic [31:0] eaddr,
                              input int eid, input int ecmd, input int rc, input int dc);
    vec_t v;
    v.rv = rv[0]; v.addr = addr; v.id = id[7:0]; v.cmd = cmd[1:0];
    v.dv = dv[0]; v.dtag = dtag[7:0]; v.ordy = ordy[0];
    v.rr = rr[0]; v.dr = dr[0]; v.ov = ov[0]; v.eaddr = eaddr;
    v.eid = eid[7:0]; v.ecmd = ecmd[1:0]; v.rc = rc[2:0]; v.dc = dc[2:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [31:0] addr, input logic [7:0] id,
                       input logic [1:0] cmd, input logic dv, input logic [7:0] dtag,
                       input logic last, input logic ordy);
    req_valid_i  = rv;
    req_addr_i   = addr;
    req_id_i     = id;
    req_size_i   = id[3:0];
    req_cmd_i    = cmd;
    req_atomic_i = ~id[3:0];
    data_valid_i = dv;
    data_i       = {64{dtag}};
    be_i         = {8{dtag}};
    last_i       = last;
    out_ready_i  = ordy;
  endtask

  task automatic chk_out(input string t, input logic rr, input logic dr, input logic ov,
                         input logic [31:0] eaddr, input logic [7:0] eid, input logic [1:0] ecmd,
                         input logic [2:0] rc, input logic [2:0] dc);
    logic [511:0] ed;
    logic [63:0]  eb;
    logic [3:0]   ea;
    logic [3:0]   es;
    ed = ov ? {64{eid}} : '0;
    eb = ov ? {8{eid}} : '0;
    es = ov ? eid[3:0] : '0;
    ea = ov ? ~eid[3:0] : '0;
    chk({t, "_req_ready"}, req_ready_o, rr);
    chk({t, "_data_ready"}, data_ready_o, dr);
    chk({t, "_out_valid"}, out_valid_o, ov);
    chk({t, "_addr"}, out_addr_o, eaddr);
    chk({t, "_id"}, out_id_o, eid);
    chk({t, "_cmd"}, out_cmd_o, ecmd);
    chk({t, "_size"}, out_size_o, es);
    chk({t, "_atomic"}, out_atomic_o, ea);
    chk({t, "_data"}, out_data_o, ed);
    chk({t, "_be"}, out_be_o, eb);
    chk({t, "_req_count"}, req_count_o, rc);
    chk({t, "_data_count"}, data_count_o, dc);
  endtask

  logic exp_err;
  int   ov_seen;

  initial begin
`ifdef MEM_WR_PAIRER_LAST_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    // Expectations are the state seen just before the edge that applies the vector's inputs.
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,         1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h80001000, 8'h05, 1, 1, 8'h05, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,         1, 1, 1, 32'h80001000, 8'h05, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,         1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h100, 8'h0A, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h200, 8'h0B, 2, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 32'h300, 8'h0C, 3, 0, 0, 1, 1, 1, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h0A, 1,     1, 1, 0, 0, 0, 0, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h0B, 1,     1, 1, 1, 32'h100, 8'h0A, 0, 3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h0C, 1,     1, 1, 1, 32'h200, 8'h0B, 2, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,         1, 1, 1, 32'h300, 8'h0C, 3, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,         1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h400, 8'h10, 1, 1, 8'h10, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h500, 8'h11, 1, 1, 8'h11, 0, 1, 1, 1, 32'h400, 8'h10, 1, 1, 1));
    vecs.push_back(mk(1, 32'h600, 8'h12, 1, 1, 8'h12, 0, 1, 1, 1, 32'h400, 8'h10, 1, 2, 2));
    vecs.push_back(mk(1, 32'h700, 8'h13, 1, 1, 8'h13, 0, 1, 1, 1, 32'h400, 8'h10, 1, 3, 3));
    vecs.push_back(mk(1, 32'h800, 8'h14, 1, 1, 8'h99, 0, 0, 0, 1, 32'h400, 8'h10, 1, 4, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,         0, 0, 1, 32'h400, 8'h10, 1, 4, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,         1, 1, 1, 32'h500, 8'h11, 1, 3, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,         1, 1, 1, 32'h600, 8'h12, 1, 2, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,         1, 1, 1, 32'h700, 8'h13, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,         1, 1, 0, 0, 0, 0, 0, 0));

    rstn_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    repeat (2) @(negedge clk_i);
    #1;
    chk_out("in_reset", 1, 1, 0, 0, 0, 0, 0, 0);
    chk("in_reset_err", err_o, 1'b0);
    rstn_i = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk_i);
      drive(vecs[i].rv, vecs[i].addr, vecs[i].id, vecs[i].cmd, vecs[i].dv, vecs[i].dtag, 1'b1, vecs[i].ordy);
      #1;
      chk_out($sformatf("v%0d", i), vecs[i].rr, vecs[i].dr, vecs[i].ov, vecs[i].eaddr,
              vecs[i].eid, vecs[i].ecmd, vecs[i].rc, vecs[i].dc);
      chk($sformatf("v%0d_err", i), err_o, 1'b0);
    end

    // Fill the request FIFO with one beat available, then push and pop in the same cycle.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      drive(1, 32'h9000 + 32'(k * 16), 8'h30 + 8'(k), 2'b01, (k == 0), 8'h30, 1, 0);
    end
    @(negedge clk_i);
    drive(1, 32'hA000, 8'h40, 2'b01, 0, 0, 1, 1);
    #1;
    chk_out("full_pre", 0, 1, 1, 32'h9000, 8'h30, 1, 4, 1);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 1, 8'h31, 1, 0);
    #1;
    chk_out("full_post", 1, 1, 0, 0, 0, 0, 3, 0);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 1, 8'h32, 1, 0);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk_out("two_pairs", 1, 1, 1, 32'h9010, 8'h31, 1, 3, 2);

    // Asynchronous reset away from any clock edge.
    #2 rstn_i = 1'b0;
    #1;
    chk_out("async_rst", 1, 1, 0, 0, 0, 0, 0, 0);
    chk("async_rst_err", err_o, 1'b0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    ov_seen = 0;
    repeat (4) begin
      @(negedge clk_i);
      #1;
      if (out_valid_o) ov_seen++;
    end
    chk("post_rst_no_output", 32'(ov_seen), 32'd0);

    // last_i check: a good beat, then a beat without last.
    @(negedge clk_i);
    drive(0, 0, 0, 0, 1, 8'h50, 1, 1);
    @(negedge clk_i);
    #1;
    chk("err_after_good_beat", err_o, 1'b0);
    drive(0, 0, 0, 0, 1, 8'h51, 0, 1);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    chk("err_after_bad_beat", err_o, exp_err);
    chk("bad_beat_buffered", data_count_o, 3'd2);
    repeat (3) @(negedge clk_i);
    #1;
    chk("err_sticky", err_o, exp_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
